// File: rtl/armleocpu_regfile_mp.sv
// armleocpu_regfile_mp
//   Multi-read-port register file with a hardware clear sequencer.
//   After reset, or after an accepted clear_req, every entry is zeroed one per
//   cycle. Reads and writes are accepted only once ready is high.
//
//   State table:
//     state   | meaning
//     S_CLEAR | zeroing entry[clr_cnt] each cycle; reads/writes ignored
//     S_READY | normal operation; clear_req restarts the clear sequence
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear_req  request to re-zero all entries (sampled in S_READY only)
//   ready      registered; high when reads/writes are accepted
//   rs_read    per-port read enable
//   rs_addr    packed read addresses, port p at [p*DEPTH_W +: DEPTH_W]
//   rs_rdata   packed registered read data, port p at [p*WIDTH +: WIDTH]
//   rd_write   write enable
//   rd_addr    write address
//   rd_wdata   write data
module armleocpu_regfile_mp #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_W    = 5,
  parameter int unsigned READ_PORTS = 2,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear_req,
  output logic                          ready,
  input  logic [READ_PORTS-1:0]         rs_read,
  input  logic [READ_PORTS*DEPTH_W-1:0] rs_addr,
  output logic [READ_PORTS*WIDTH-1:0]   rs_rdata,
  input  logic                          rd_write,
  input  logic [DEPTH_W-1:0]            rd_addr,
  input  logic [WIDTH-1:0]              rd_wdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t               state;
  logic [DEPTH_W-1:0]   clr_cnt;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 wr_en;
  logic [DEPTH_W-1:0]   rs_a    [READ_PORTS];
  logic [WIDTH-1:0]     rd_next [READ_PORTS];

  // Writes to entry 0 are dropped when it is hardwired to zero.
  assign wr_en = rd_write && !(ZERO_REG && (rd_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            state <= S_READY;
            ready <= 1'b1;
          end
        end
        S_READY: begin
          if (clear_req) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
          end
        end
        default: begin
          state   <= S_CLEAR;
          clr_cnt <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the clear sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      mem[rd_addr] <= rd_wdata;
    end
  end

  // Read mux: the zero-register rule overrides the bypass path.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rs_a[p]    = rs_addr[p*DEPTH_W +: DEPTH_W];
      rd_next[p] = mem[rs_a[p]];
      if (BYPASS && rd_write && (rd_addr == rs_a[p])) begin
        rd_next[p] = rd_wdata;
      end
      if (ZERO_REG && (rs_a[p] == '0)) begin
        rd_next[p] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_rdata <= '0;
    end else if (state == S_READY) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        if (rs_read[p]) begin
          rs_rdata[p*WIDTH +: WIDTH] <= rd_next[p];
        end
      end
    end
  end

endmodule

// File: doc/armleocpu_regfile_mp.md
# armleocpu_regfile_mp

Parametrised multi-read-port register file for ArmleoCPU cores. It generalises the fixed two-read, one-write, 32×32 register file to configurable width, depth and read-port count. It adds a hardware clear sequencer, a synchronous re-clear request and optional write-to-read bypass. It sits between decode/issue (read side) and writeback (write side).

## Interface
- WIDTH, 32, data width per register
- DEPTH_W, 5, address width; entry count DEPTH = 2**DEPTH_W
- READ_PORTS, 2, number of independent read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero (writes to it dropped)
- BYPASS, 1, when 1 same-cycle write data forwards to a read of the same address

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear_req  in  1  synchronous request to re-zero all entries; sampled only in READY
- ready  out  1  high when reads/writes are accepted
- rs_read  in  READ_PORTS  per-port read enable
- rs_addr  in  READ_PORTS*DEPTH_W  packed read addresses; port p at [p*DEPTH_W +: DEPTH_W]
- rs_rdata  out  READ_PORTS*WIDTH  packed registered read data; port p at [p*WIDTH +: WIDTH]
- rd_write  in  1  write enable
- rd_addr  in  DEPTH_W  write address
- rd_wdata  in  WIDTH  write data

## Operation
- State machine with two states, CLEAR and READY.
  - Asynchronous reset: state=CLEAR, clear counter=0, ready=0, all rs_rdata=0.
  - CLEAR: each cycle writes 0 to entry[counter], then counter increments. When counter==DEPTH-1, that entry is written and the next state is READY. The counter wraps to 0.
  - READY with clear_req=1: next state CLEAR, counter=0. The rd_write and rs_read inputs of that same cycle are still honoured.
- In CLEAR:
  - rd_write is ignored.
  - rs_read is ignored; rs_rdata holds its value (0 after reset).
- Write (READY only): when rd_write=1, entry[rd_addr] <= rd_wdata. If ZERO_REG=1 and rd_addr==0, the write is dropped.
- Read (READY only): per port p, when rs_read[p]=1, rs_rdata[p] <= entry[rs_addr[p]]. When rs_read[p]=0, rs_rdata[p] holds.
- Read of address 0 with ZERO_REG=1 always returns 0.
- Same-address read and write in the same cycle:
  - BYPASS=1: read returns rd_wdata (write-first).
  - BYPASS=0: read returns the old content.
  - In both cases the address-0 rule with ZERO_REG=1 has priority.
- Multiple ports reading the same address are legal; all return identical data.
- Storage is a flop array or per-port RAM lanes with a common write. The implementation is free, but it must be cycle-equivalent to the above.

## Timing
- Read latency: 1 cycle. Address and enable sampled at edge N; data visible after edge N and held until the next enabled read.
- Write visible to a normal read issued at edge N+1 or later. A same-edge read obeys the BYPASS rule.
- Clear duration: DEPTH cycles after rst_n deassert, or after the edge accepting clear_req. ready rises after the edge that clears entry DEPTH-1.
  - DEPTH=32: ready=1 on the 32nd rising edge after reset release.
- rst_n assertion mid-CLEAR restarts the sequence at counter 0 on release. rst_n assertion mid-READY clears rs_rdata immediately (asynchronously).
- clear_req during CLEAR is ignored; no restart.
- ready is registered with no combinational path from any input.

## Test plan
- Reset release, DEPTH_W=5, hold rs_read=1 for all ports -> ready=0 for exactly 32 edges then 1; rs_rdata stays 0; reading every entry afterwards returns 0.
- Write 0xDEADBEEF to addr 7, then read addr 7 on port 0 and port 1 next cycle -> both ports show 0xDEADBEEF one cycle after the read edge.
- Write 0x12345678 to addr 3 while port 0 reads addr 3 in the same cycle -> BYPASS=1 returns 0x12345678; BYPASS=0 returns the prior value 0x0.
- Write 0xFFFFFFFF to addr 0 with ZERO_REG=1, then read addr 0 -> 0x0. Rerun with ZERO_REG=0 -> 0xFFFFFFFF.
- Fill all entries with value=address, pulse clear_req, and attempt a write of 0xAA to addr 5 at cycle 10 of CLEAR -> ready low 32 cycles; afterwards every entry reads 0, including addr 5.
- Assert rst_n low at cycle 15 of CLEAR for 1 cycle -> after release the full 32-cycle CLEAR repeats before ready=1.
